// File: rtl/riscv_multicycle_core.sv
// Multi-cycle RV32I/RV32E core: one shared valid/ready memory port, FSM-sequenced datapath,
// retired-instruction counter and a terminal halt state on any trap.
module riscv_multicycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        halted,
  output logic [31:0] instret,
  output logic [31:0] pc_out
);
  localparam int unsigned XLEN   = 32;
  localparam int unsigned RIDX_W = $clog2(NUM_REGS);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d, imm_q, imm_d;
  logic [XLEN-1:0]   alu_q, alu_d, mdr_q, mdr_d, npc_q, npc_d, instret_q, instret_d;
  logic              halted_q, halted_d;
  logic [XLEN-1:0]   rf_q [NUM_REGS];

  logic [6:0]        opcode, f7;
  logic [4:0]        rd, rs1, rs2;
  logic [2:0]        f3;
  logic [XLEN-1:0]   imm_dec, op2, alu_res, pc_4, pc_imm, a_imm, jtgt, wb_data;
  logic              legal, use_rd, use_rs1, use_rs2, wb_en, take, rf_we;

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign f3     = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign f7     = ir_q[31:25];

  assign pc_4    = pc_q + 32'd4;
  assign pc_imm  = pc_q + imm_q;
  assign a_imm   = a_q + imm_q;
  assign jtgt    = (opcode == OP_JALR) ? {a_imm[31:1], 1'b0} : pc_imm;
  assign op2     = (opcode == OP_OP) ? b_q : imm_q;
  assign wb_data = (opcode == OP_LOAD) ? mdr_q : alu_q;
  assign wb_en   = (opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL) ||
                   (opcode == OP_JALR) || (opcode == OP_LOAD) || (opcode == OP_IMM) ||
                   (opcode == OP_OP);

  // Memory request decoded from state; reset kills it without waiting for a clock.
  assign mem_valid = !reset && ((state_q == S_FETCH) || (state_q == S_MEM));
  assign mem_we    = !reset && (state_q == S_MEM) && (opcode == OP_STORE);
  assign mem_addr  = (state_q == S_MEM) ? alu_q : pc_q;
  assign mem_wdata = b_q;
  assign halted    = halted_q;
  assign instret   = instret_q;
  assign pc_out    = pc_q;

  always_comb begin
    case (opcode)
      OP_LUI, OP_AUIPC: imm_dec = {ir_q[31:12], 12'b0};
      OP_JAL:    imm_dec = {{12{ir_q[31]}}, ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
      OP_BRANCH: imm_dec = {{20{ir_q[31]}}, ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      OP_STORE:  imm_dec = {{21{ir_q[31]}}, ir_q[30:25], ir_q[11:7]};
      default:   imm_dec = {{21{ir_q[31]}}, ir_q[30:20]};
    endcase
  end

  // Legality: supported encodings, then register indices against the configured file size.
  always_comb begin
    legal   = 1'b0;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL: begin legal = 1'b1; use_rd = 1'b1; end
      OP_JALR:   begin legal = (f3 == 3'b000); use_rd = 1'b1; use_rs1 = 1'b1; end
      OP_BRANCH: begin legal = (f3 != 3'b010) && (f3 != 3'b011); use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_LOAD:   begin legal = (f3 == 3'b010); use_rd = 1'b1; use_rs1 = 1'b1; end
      OP_STORE:  begin legal = (f3 == 3'b010); use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_IMM: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        if (f3 == 3'b001)      legal = (f7 == 7'b0000000);
        else if (f3 == 3'b101) legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
        else                   legal = 1'b1;
      end
      OP_OP: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        legal   = (f7 == 7'b0000000) ||
                  ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
      end
      OP_FENCE:  legal = (f3 == 3'b000);
      default:   legal = 1'b0;
    endcase
    if (use_rd  && (32'(rd)  >= NUM_REGS)) legal = 1'b0;
    if (use_rs1 && (32'(rs1) >= NUM_REGS)) legal = 1'b0;
    if (use_rs2 && (32'(rs2) >= NUM_REGS)) legal = 1'b0;
  end

  always_comb begin
    alu_res = '0;
    case (f3)
      3'b000: alu_res = ((opcode == OP_OP) && f7[5]) ? a_q - op2 : a_q + op2;
      3'b001: alu_res = a_q << op2[4:0];
      3'b010: alu_res = {31'd0, $signed(a_q) < $signed(op2)};
      3'b011: alu_res = {31'd0, a_q < op2};
      3'b100: alu_res = a_q ^ op2;
      3'b101: alu_res = f7[5] ? 32'($signed(a_q) >>> op2[4:0]) : a_q >> op2[4:0];
      3'b110: alu_res = a_q | op2;
      default: alu_res = a_q & op2;
    endcase
    case (f3)
      3'b000:  take = (a_q == b_q);
      3'b001:  take = (a_q != b_q);
      3'b100:  take = ($signed(a_q) < $signed(b_q));
      3'b101:  take = ($signed(a_q) >= $signed(b_q));
      3'b110:  take = (a_q < b_q);
      default: take = (a_q >= b_q);
    endcase
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    imm_d     = imm_q;
    alu_d     = alu_q;
    mdr_d     = mdr_q;
    npc_d     = npc_q;
    instret_d = instret_q;
    halted_d  = halted_q;
    rf_we     = 1'b0;
    case (state_q)
      S_FETCH: if (mem_ready) begin
        ir_d    = mem_rdata;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        a_d      = (rs1 == 5'd0) ? '0 : rf_q[rs1[RIDX_W-1:0]];
        b_d      = (rs2 == 5'd0) ? '0 : rf_q[rs2[RIDX_W-1:0]];
        imm_d    = imm_dec;
        state_d  = legal ? S_EXECUTE : S_HALT;
        halted_d = !legal;
      end
      S_EXECUTE: begin
        alu_d   = alu_res;
        npc_d   = pc_4;
        state_d = S_WB;
        case (opcode)
          OP_BRANCH: begin
            if (take && (pc_imm[1:0] != 2'b00)) begin
              state_d  = S_HALT;
              halted_d = 1'b1;
            end else begin
              pc_d      = take ? pc_imm : pc_4;
              instret_d = instret_q + 32'd1;
              state_d   = S_FETCH;
            end
          end
          OP_JAL, OP_JALR: begin
            alu_d = pc_4;
            npc_d = jtgt;
            if (jtgt[1:0] != 2'b00) begin
              state_d  = S_HALT;
              halted_d = 1'b1;
            end
          end
          OP_LOAD, OP_STORE: begin
            alu_d = a_imm;
            if (a_imm[1:0] != 2'b00) begin
              state_d  = S_HALT;
              halted_d = 1'b1;
            end else begin
              state_d = S_MEM;
            end
          end
          OP_LUI:   alu_d = imm_q;
          OP_AUIPC: alu_d = pc_imm;
          default:  ;
        endcase
      end
      S_MEM: if (mem_ready) begin
        if (opcode == OP_STORE) begin
          pc_d      = pc_4;
          instret_d = instret_q + 32'd1;
          state_d   = S_FETCH;
        end else begin
          mdr_d   = mem_rdata;
          state_d = S_WB;
        end
      end
      S_WB: begin
        rf_we     = wb_en && (rd != 5'd0);
        pc_d      = npc_q;
        instret_d = instret_q + 32'd1;
        state_d   = S_FETCH;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      imm_q     <= '0;
      alu_q     <= '0;
      mdr_q     <= '0;
      npc_q     <= '0;
      instret_q <= '0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      imm_q     <= imm_d;
      alu_q     <= alu_d;
      mdr_q     <= mdr_d;
      npc_q     <= npc_d;
      instret_q <= instret_d;
      halted_q  <= halted_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[rd[RIDX_W-1:0]] <= wb_data;
    end
  end
endmodule
